// File: rtl/psum_drain_pkg.sv
// Shared types and sizing helpers for the partial-sum drain chain.
package psum_drain_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic int calc_nb(input int num_col, input int num_lane);
    return num_col / num_lane;
  endfunction

  function automatic int cnt_w(input int nb);
    return (nb <= 1) ? 1 : $clog2(nb);
  endfunction

endpackage

// File: rtl/psum_requant.sv
// Combinational requantiser: rounded arithmetic right shift, optional ReLU, saturation.
module psum_requant #(
  parameter int DATA_W  = 24,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic signed [DATA_W-1:0]  psum_i,
  input  logic        [SHIFT_W-1:0] shift_amt_i,
  input  logic                      relu_en_i,
  output logic signed [OUT_W-1:0]   word_o
);

  localparam logic signed [DATA_W:0] MAX_V = {{(DATA_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] MIN_V = {{(DATA_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [DATA_W:0]  ext_s;
  logic signed [DATA_W:0]  shr_s;
  logic signed [DATA_W:0]  rnd_src_s;
  logic signed [DATA_W:0]  sum_s;
  logic signed [DATA_W:0]  relu_s;
  logic        [SHIFT_W-1:0] shm1_s;
  logic                    rnd_bit_s;

  // One extra bit of headroom keeps the rounding add from wrapping at full scale.
  always_comb begin
    ext_s     = {psum_i[DATA_W-1], psum_i};
    shr_s     = ext_s >>> shift_amt_i;
    shm1_s    = shift_amt_i - SHIFT_W'(1);
    rnd_src_s = ext_s >>> shm1_s;
    if (shift_amt_i != {SHIFT_W{1'b0}}) begin
      rnd_bit_s = rnd_src_s[0];
    end else begin
      rnd_bit_s = 1'b0;
    end
    sum_s = shr_s + $signed({{DATA_W{1'b0}}, rnd_bit_s});
    if (relu_en_i && sum_s[DATA_W]) begin
      relu_s = '0;
    end else begin
      relu_s = sum_s;
    end
    if (relu_s > MAX_V) begin
      word_o = MAX_V[OUT_W-1:0];
    end else if (relu_s < MIN_V) begin
      word_o = MIN_V[OUT_W-1:0];
    end else begin
      word_o = relu_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_drain_chain.sv
// Snapshots the PE array partial sums and drains them NUM_LANE columns per beat,
// rightmost column group first, through per-lane requantisers.
module psum_drain_chain
  import psum_drain_pkg::*;
#(
  parameter int NUM_ROW  = 4,
  parameter int NUM_COL  = 8,
  parameter int NUM_LANE = 2,
  parameter int DATA_W   = 24,
  parameter int OUT_W    = 16,
  parameter int SHIFT_W  = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_ROW*NUM_COL*DATA_W-1:0] psum_in,
  input  logic                              capture,
  input  logic [SHIFT_W-1:0]                shift_amt,
  input  logic                              relu_en,
  output logic [NUM_ROW*NUM_LANE*OUT_W-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              capture_drop,
  output logic                              frame_done
);

  localparam int NB = calc_nb(NUM_COL, NUM_LANE);
  localparam int CW = cnt_w(NB);
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic                relu_q, relu_d;
  logic                drop_q, drop_d;
  logic                done_q, done_d;
  logic                load_s, shift_en_s, hs_s, last_s;

  logic signed [DATA_W-1:0] data_q [NUM_ROW][NUM_COL];
  logic signed [DATA_W-1:0] data_d [NUM_ROW][NUM_COL];

  assign out_valid    = (state_q == DRAIN);
  assign busy         = (state_q == DRAIN);
  assign last_s       = out_valid && (beat_cnt_q == LAST_CNT);
  assign out_last     = last_s;
  assign hs_s         = out_valid && out_ready;
  assign capture_drop = drop_q;
  assign frame_done   = done_q;

  // A capture coinciding with the final handshake reloads instead of draining to IDLE.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    drop_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          load_s     = 1'b1;
          beat_cnt_d = '0;
          state_d    = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (hs_s && last_s) begin
          done_d     = 1'b1;
          beat_cnt_d = '0;
          if (capture) begin
            load_s  = 1'b1;
            state_d = DRAIN;
          end else begin
            shift_en_s = 1'b1;
            state_d    = IDLE;
          end
        end else if (hs_s) begin
          shift_en_s = 1'b1;
          beat_cnt_d = beat_cnt_q + CW'(1);
          drop_d     = capture;
        end else begin
          drop_d = capture;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
    if (load_s) begin
      shift_d = shift_amt;
      relu_d  = relu_en;
    end else begin
      shift_d = shift_q;
      relu_d  = relu_q;
    end
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      if (c >= NUM_LANE) begin : g_mid
        assign data_d[r][c] = load_s     ? $signed(psum_in[(r*NUM_COL+c)*DATA_W +: DATA_W]) :
                              shift_en_s ? data_q[r][c-NUM_LANE] : data_q[r][c];
      end else begin : g_head
        assign data_d[r][c] = load_s     ? $signed(psum_in[(r*NUM_COL+c)*DATA_W +: DATA_W]) :
                              shift_en_s ? '0 : data_q[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      drop_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int r = 0; r < NUM_ROW; r++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          data_q[r][c] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_rq_row
    for (genvar l = 0; l < NUM_LANE; l++) begin : g_rq_lane
      psum_requant #(
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
      ) u_requant (
        .psum_i      (data_q[r][NUM_COL-NUM_LANE+l]),
        .shift_amt_i (shift_q),
        .relu_en_i   (relu_q),
        .word_o      (out_data[(r*NUM_LANE+l)*OUT_W +: OUT_W])
      );
    end
  end

endmodule
